// File: rtl/bus_pkg.sv
// Shared widths, window geometry and responder states
// for the burst bus SRAM target.
package bus_pkg;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int BURST_W    = 8;
    localparam int BE_W       = 4;
    localparam int WORDS      = 512;
    localparam int INDEX_W    = $clog2(WORDS);
    localparam int WINDOW_LSB = INDEX_W + 2;

    localparam logic [INDEX_W:0] LAST_INDEX = (INDEX_W + 1)'(WORDS - 1);

    typedef enum logic [2:0] {
        IDLE,
        WR_SETUP,
        WRITE,
        RD_FETCH,
        READ,
        RD_END,
        ERROR
    } state_t;

    // One bit wider than the index so a burst running off the end is caught.
    function automatic logic burst_overflows(
        input logic [INDEX_W-1:0] idx,
        input logic [BURST_W-1:0] burst
    );
        logic [INDEX_W:0] last;
        last = {1'b0, idx} + {{(INDEX_W + 1 - BURST_W){1'b0}}, burst};
        return last > LAST_INDEX;
    endfunction

endpackage

// File: rtl/sram512x32_be.sv
// Single-port synchronous SRAM, one-cycle read latency,
// per-byte write enables.
module sram512x32_be
    import bus_pkg::*;
(
    input  logic               clock,
    input  logic               en,
    input  logic [BE_W-1:0]    we,
    input  logic [INDEX_W-1:0] addr,
    input  logic [DATA_W-1:0]  wdata,
    output logic [DATA_W-1:0]  rdata
);

    logic [DATA_W-1:0] mem [WORDS];

    always_ff @(posedge clock) begin
        for (int i = 0; i < BE_W; i++) begin
            if (we[i]) begin
                mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        if (en) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/bus_sram_slave.sv
// Burst bus target fronting a 512x32 SRAM in a fixed 2 KB window:
// single/burst reads and writes, bus error on illegal access.
module bus_sram_slave
    import bus_pkg::*;
#(
    parameter logic [ADDR_W-1:0] baseAddress = 32'h5000_0000
)
(
    input  logic               clock,
    input  logic               reset,
    input  logic               beginTransactionIn,
    input  logic [ADDR_W-1:0]  addressDataIn,
    input  logic [BE_W-1:0]    byteEnablesIn,
    input  logic [BURST_W-1:0] burstSizeIn,
    input  logic               readNotWriteIn,
    input  logic               dataValidIn,
    input  logic               endTransactionIn,
    output logic [DATA_W-1:0]  addressDataOut,
    output logic               dataValidOut,
    output logic               endTransactionOut,
    output logic               busyOut,
    output logic               busErrorOut
);

    state_t               state;
    logic [INDEX_W-1:0]   index;
    logic [BURST_W-1:0]   count;
    logic [BE_W-1:0]      be;

    logic [INDEX_W-1:0]   reqIndex;
    logic                 hit;
    logic                 badAccess;

    logic                 ramEn;
    logic [BE_W-1:0]      ramWe;
    logic [DATA_W-1:0]    ramQ;

    assign reqIndex = addressDataIn[WINDOW_LSB-1:2];
    assign hit = addressDataIn[ADDR_W-1:WINDOW_LSB]
              == baseAddress[ADDR_W-1:WINDOW_LSB];
    assign badAccess = (|addressDataIn[1:0])
                    || burst_overflows(reqIndex, burstSizeIn);

    // The RAM address is always the running index; in READ it
    // already points one word ahead of what is on the bus.
    assign ramEn = (state == RD_FETCH) || (state == READ);
    assign ramWe = (state == WRITE && dataValidIn && !reset)
                 ? be : '0;

    sram512x32_be u_sram (
        .clock (clock),
        .en    (ramEn),
        .we    (ramWe),
        .addr  (index),
        .wdata (addressDataIn),
        .rdata (ramQ)
    );

    assign addressDataOut = dataValidOut ? ramQ : '0;

    always_ff @(posedge clock) begin
        if (reset) begin
            state             <= IDLE;
            index             <= '0;
            count             <= '0;
            be                <= '0;
            dataValidOut      <= 1'b0;
            endTransactionOut <= 1'b0;
            busyOut           <= 1'b0;
            busErrorOut       <= 1'b0;
        end else begin
            dataValidOut      <= 1'b0;
            endTransactionOut <= 1'b0;
            busyOut           <= 1'b0;
            busErrorOut       <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (beginTransactionIn && hit) begin
                        if (badAccess) begin
                            state       <= ERROR;
                            busErrorOut <= 1'b1;
                        end else begin
                            index <= reqIndex;
                            count <= burstSizeIn;
                            be    <= byteEnablesIn;
                            if (readNotWriteIn) begin
                                state <= RD_FETCH;
                            end else begin
                                state   <= WR_SETUP;
                                busyOut <= 1'b1;
                            end
                        end
                    end
                end
                WR_SETUP: begin
                    state <= WRITE;
                end
                WRITE: begin
                    if (dataValidIn) begin
                        index <= index + 1'b1;
                        if (endTransactionIn || count == '0) begin
                            state <= IDLE;
                        end else begin
                            count <= count - 1'b1;
                        end
                    end else if (endTransactionIn) begin
                        state <= IDLE;
                    end
                end
                RD_FETCH: begin
                    index        <= index + 1'b1;
                    state        <= READ;
                    dataValidOut <= 1'b1;
                end
                READ: begin
                    if (endTransactionIn) begin
                        state <= IDLE;
                    end else if (count == '0) begin
                        state             <= RD_END;
                        endTransactionOut <= 1'b1;
                    end else begin
                        count        <= count - 1'b1;
                        index        <= index + 1'b1;
                        dataValidOut <= 1'b1;
                    end
                end
                RD_END: begin
                    state <= IDLE;
                end
                ERROR: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_sram_slave.sv
// Scoreboard bench for bus_sram_slave: a word-array model predicts
// every output cycle; a negedge monitor compares.
module tb_bus_sram_slave;

    localparam logic [31:0] BASE = 32'h5000_0000;
    localparam logic [3:0] F_DV   = 4'b0001;
    localparam logic [3:0] F_END  = 4'b0010;
    localparam logic [3:0] F_ERR  = 4'b0100;
    localparam logic [3:0] F_BUSY = 4'b1000;

    logic        clock = 1'b0;
    logic        reset;
    logic        beginTransactionIn;
    logic [31:0] addressDataIn;
    logic [3:0]  byteEnablesIn;
    logic [7:0]  burstSizeIn;
    logic        readNotWriteIn;
    logic        dataValidIn;
    logic        endTransactionIn;
    logic [31:0] addressDataOut;
    logic        dataValidOut;
    logic        endTransactionOut;
    logic        busyOut;
    logic        busErrorOut;

    always #5 clock = ~clock;

    bus_sram_slave #(.baseAddress(BASE)) dut (
        .clock             (clock),
        .reset             (reset),
        .beginTransactionIn(beginTransactionIn),
        .addressDataIn     (addressDataIn),
        .byteEnablesIn     (byteEnablesIn),
        .burstSizeIn       (burstSizeIn),
        .readNotWriteIn    (readNotWriteIn),
        .dataValidIn       (dataValidIn),
        .endTransactionIn  (endTransactionIn),
        .addressDataOut    (addressDataOut),
        .dataValidOut      (dataValidOut),
        .endTransactionOut (endTransactionOut),
        .busyOut           (busyOut),
        .busErrorOut       (busErrorOut)
    );

    typedef struct {
        int          cycle;
        logic [3:0]  flags;
        logic [31:0] data;
    } ev_t;

    ev_t         expq[$];
    logic [31:0] model [512];
    logic [31:0] wq[$];
    int          cyc = 0;
    int          compared = 0;
    int          mismatched = 0;
    bit          monitorOn = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin : monitor
        logic [3:0]  obs;
        logic [3:0]  ef;
        logic [31:0] ed;
        if (monitorOn) begin
            obs = {busyOut, busErrorOut, endTransactionOut, dataValidOut};
            while (expq.size() > 0 && expq[0].cycle < cyc) begin
                compared++;
                mismatched++;
                $display("FAIL missing-event cyc=%0d flags got none want %b",
                         expq[0].cycle, expq[0].flags);
                void'(expq.pop_front());
            end
            ef = 4'b0;
            ed = 32'h0;
            if (expq.size() > 0 && expq[0].cycle == cyc) begin
                ef = expq[0].flags;
                ed = expq[0].data;
                void'(expq.pop_front());
            end
            compared++;
            if (obs !== ef || addressDataOut !== ed) begin
                mismatched++;
                $display("FAIL outputs cyc=%0d flags(busy,err,end,dv) got %b want %b data got %h want %h",
                         cyc, obs, ef, addressDataOut, ed);
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        beginTransactionIn = 1'b0;
        addressDataIn      = 32'h0;
        byteEnablesIn      = 4'h0;
        burstSizeIn        = 8'h0;
        readNotWriteIn     = 1'b0;
        dataValidIn        = 1'b0;
        endTransactionIn   = 1'b0;
    endtask

    task automatic push(input int c, input logic [3:0] f, input logic [31:0] d);
        ev_t e;
        e.cycle = c;
        e.flags = f;
        e.data  = d;
        expq.push_back(e);
    endtask

    function automatic logic [31:0] next_data();
        if (wq.size() > 0) return wq.pop_front();
        return $urandom;
    endfunction

    function automatic logic [31:0] bemask(input logic [3:0] be);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{be[i]}};
        return m;
    endfunction

    function automatic bit in_window(input logic [31:0] a);
        return a >= BASE && a <= BASE + 32'd2047;
    endfunction

    task automatic stray();
        if ($urandom_range(0, 3) == 0) begin
            beginTransactionIn = 1'b1;
            addressDataIn = BASE + 32'($urandom_range(0, 511)) * 4;
            readNotWriteIn = 1'($urandom);
            burstSizeIn = 8'($urandom);
            byteEnablesIn = 4'hF;
        end
    endtask

    // Returns 1 when the begin was consumed by no-hit or error handling.
    task automatic start(input logic [31:0] addr, input int burst,
                         input logic [3:0] be, input bit rd,
                         output int t, output int idx, output bit done);
        logic [31:0] off;
        beginTransactionIn = 1'b1;
        addressDataIn = addr;
        byteEnablesIn = be;
        burstSizeIn = 8'(burst);
        readNotWriteIn = rd;
        t = cyc;
        off = addr - BASE;
        idx = int'(off / 4);
        done = 1'b1;
        if (!in_window(addr)) begin
            step();
            idle();
        end else if (off % 4 != 0 || idx + burst > 511) begin
            push(t + 1, F_ERR, 32'h0);
            step();
            idle();
            step();
        end else begin
            done = 1'b0;
        end
    endtask

    task automatic do_write(input logic [31:0] addr, input int burst,
                            input logic [3:0] be, input int abortAt,
                            input bit useReset);
        int t, idx, n;
        bit done;
        logic [31:0] d;
        start(addr, burst, be, 1'b0, t, idx, done);
        if (done) return;
        push(t + 1, F_BUSY, 32'h0);
        n = (abortAt >= 1) ? abortAt : burst + 1;
        d = next_data();
        step();
        idle();
        dataValidIn = 1'b1;
        addressDataIn = d;
        for (int k = 0; k < n; k++) begin
            step();
            idle();
            if ($urandom_range(0, 3) == 0) step();
            dataValidIn = 1'b1;
            addressDataIn = d;
            if (k == n - 1 && abortAt >= 1 && !useReset)
                endTransactionIn = 1'b1;
            model[idx + k] = (model[idx + k] & ~bemask(be)) | (d & bemask(be));
            d = next_data();
        end
        step();
        idle();
        if (useReset) begin
            reset = 1'b1;
            step();
            reset = 1'b0;
            dataValidIn = 1'b1;
            addressDataIn = $urandom;
            step();
            addressDataIn = $urandom;
            step();
            idle();
        end
    endtask

    task automatic do_read(input logic [31:0] addr, input int burst,
                           input int abortAt, input bit useReset);
        int t, idx, n;
        bit done;
        start(addr, burst, 4'($urandom), 1'b1, t, idx, done);
        if (done) return;
        n = (abortAt >= 1) ? abortAt : burst + 1;
        for (int k = 0; k < n; k++) push(t + 2 + k, F_DV, model[idx + k]);
        if (abortAt < 1) push(t + 3 + burst, F_END, 32'h0);
        step();
        idle();
        for (int k = 0; k < n; k++) begin
            step();
            idle();
            if (k == n - 1 && abortAt >= 1) begin
                if (useReset) reset = 1'b1;
                else endTransactionIn = 1'b1;
            end else begin
                stray();
            end
        end
        step();
        reset = 1'b0;
        idle();
        if (abortAt < 1) begin
            stray();
            step();
            idle();
        end
    endtask

    initial begin
        int idx, burst, abortAt, op;
        bit useReset;
        logic [31:0] addr;
        idle();
        reset = 1'b1;
        step();
        monitorOn = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();

        do_write(BASE, 255, 4'hF, -1, 1'b0);
        do_write(BASE + 32'd1024, 255, 4'hF, -1, 1'b0);

        for (int i = 0; i < 4; i++) wq.push_back(32'hA0 + 32'(i));
        do_write(BASE + 32'h10, 3, 4'hF, -1, 1'b0);
        do_read(BASE + 32'h10, 3, -1, 1'b0);

        wq.push_back(32'hFFFF_FFFF);
        do_write(BASE, 0, 4'hF, -1, 1'b0);
        wq.push_back(32'h1234_5678);
        do_write(BASE, 0, 4'b0101, -1, 1'b0);
        do_read(BASE, 0, -1, 1'b0);

        do_write(BASE + 32'h7FC, 1, 4'hF, -1, 1'b0);
        do_read(BASE + 32'h7FC, 0, -1, 1'b0);
        do_read(BASE + 32'h2, 0, -1, 1'b0);
        do_write(32'h6000_0000, 0, 4'hF, -1, 1'b0);
        do_read(32'h6000_0000, 3, -1, 1'b0);

        do_read(BASE + 32'h40, 7, 3, 1'b0);
        do_read(BASE + 32'h40, 0, -1, 1'b0);

        do_write(BASE, 7, 4'hF, 2, 1'b1);
        do_read(BASE, 7, -1, 1'b0);
        do_read(BASE + 32'h100, 7, 4, 1'b1);
        do_read(BASE + 32'h100, 1, -1, 1'b0);

        for (int i = 0; i < 80; i++) begin
            op = $urandom_range(0, 9);
            idx = $urandom_range(0, 511);
            burst = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 255)
                                                : $urandom_range(0, 15);
            addr = BASE + 32'(idx) * 4;
            if ($urandom_range(0, 9) == 0) addr = addr + 32'($urandom_range(1, 3));
            if ($urandom_range(0, 14) == 0) addr = $urandom;
            abortAt = -1;
            useReset = 1'b0;
            if (burst > 0 && $urandom_range(0, 4) == 0) begin
                abortAt = $urandom_range(1, burst);
                useReset = ($urandom_range(0, 3) == 0);
            end
            if (op < 5) do_write(addr, burst, 4'($urandom), abortAt, useReset);
            else do_read(addr, burst, abortAt, useReset);
        end

        for (int i = 0; i < 8; i++) do_read(BASE + 32'($urandom_range(0, 480)) * 4, 31, -1, 1'b0);

        step();
        step();
        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
